// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-to-UART streamer: FSM state encoding and
// the width helpers the streamer and its tests derive their counters from.
package mat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_e;

  localparam int BYTE_W = 8;

  function automatic int bytes_of(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Counter width for an index over n values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with optional rising-edge detection on the synchronised
// level. EDGE=0 passes the level, EDGE=1 emits a one-cycle pulse per rising edge.
module sync_edge #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o = EDGE ? (sync_q & ~prev_q) : sync_q;

endmodule

// File: rtl/mat_uart_streamer.sv
// Streams a ROWS x COLS matrix from the result memory to the UART transmitter,
// element by element, MSB byte first, in row- or column-major order.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a start edge; outputs idle
// ST_READ    | read strobe for the current element address
// ST_LOAD    | capture read data into the byte shift register
// ST_SEND    | tx_start high until the transmitter reports busy
// ST_WAIT_TX | wait for the transmitter to finish the current byte
module mat_uart_streamer
  import mat_pkg::*;
#(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             col_major,
  input  logic                             abort,
  output logic                             mem_rd_en,
  output logic [ADDR_W-1:0]                mem_rd_addr,
  input  logic [DATA_W-1:0]                mem_rd_data,
  output logic                             tx_start,
  output logic [7:0]                       tx_byte,
  input  logic                             tx_busy,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted,
  output logic [$clog2(ROWS*COLS+1)-1:0]   elem_cnt
);

  localparam int NELEM = ROWS * COLS;
  localparam int BYTES = bytes_of(DATA_W);
  localparam int EC_W  = $clog2(NELEM + 1);
  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);
  localparam int BI_W  = idx_w(BYTES);

  localparam logic [EC_W-1:0]   EC_LAST     = EC_W'(NELEM - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ROWS - 1);
  localparam logic [BI_W-1:0]   BI_LAST     = BI_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(COLS);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [BI_W-1:0]     byte_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [EC_W-1:0]     elem_q;
  logic                colm_q;
  logic                rd_en_q;
  logic                tx_start_q;
  logic                busy_q;
  logic                done_q;
  logic                aborted_q;

  logic                start_rise;
  logic                tx_busy_s;

  sync_edge #(.EDGE(1'b1)) u_start_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (start),
    .q_o   (start_rise)
  );

  sync_edge #(.EDGE(1'b0)) u_busy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (tx_busy),
    .q_o   (tx_busy_s)
  );

  // Next element address. Column-major walks down a column by adding COLS and
  // restarts at the top of the next column, so no multiply is ever needed.
  always_comb begin
    addr_d = addr_q + 1'b1;
    row_d  = row_q;
    col_d  = col_q;
    if (colm_q) begin
      if (row_q == ROW_LAST) begin
        row_d  = '0;
        col_d  = col_q + 1'b1;
        addr_d = ADDR_W'(col_q) + 1'b1;
      end else begin
        row_d  = row_q + 1'b1;
        addr_d = addr_q + ADDR_STRIDE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      byte_q     <= '0;
      shreg_q    <= '0;
      elem_q     <= '0;
      colm_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        // A byte already taken by the transmitter finishes on its own.
        state_q    <= ST_IDLE;
        rd_en_q    <= 1'b0;
        tx_start_q <= 1'b0;
        busy_q     <= 1'b0;
        aborted_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_rise) begin
              state_q <= ST_READ;
              rd_en_q <= 1'b1;
              busy_q  <= 1'b1;
              elem_q  <= '0;
              addr_q  <= '0;
              row_q   <= '0;
              col_q   <= '0;
              colm_q  <= col_major;
            end
          end
          ST_READ: begin
            rd_en_q <= 1'b0;
            state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            shreg_q    <= mem_rd_data;
            byte_q     <= '0;
            tx_start_q <= 1'b1;
            state_q    <= ST_SEND;
          end
          ST_SEND: begin
            if (tx_busy_s) begin
              tx_start_q <= 1'b0;
              state_q    <= ST_WAIT_TX;
            end
          end
          ST_WAIT_TX: begin
            if (!tx_busy_s) begin
              if (byte_q != BI_LAST) begin
                shreg_q    <= shreg_q << 8;
                byte_q     <= byte_q + 1'b1;
                tx_start_q <= 1'b1;
                state_q    <= ST_SEND;
              end else begin
                elem_q <= elem_q + 1'b1;
                if (elem_q == EC_LAST) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                end else begin
                  addr_q  <= addr_d;
                  row_q   <= row_d;
                  col_q   <= col_d;
                  rd_en_q <= 1'b1;
                  state_q <= ST_READ;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = addr_q;
  assign tx_start    = tx_start_q;
  assign tx_byte     = shreg_q[DATA_W-1 -: 8];
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign elem_cnt    = elem_q;

endmodule

// File: tb/tb_mat_uart_streamer.sv
// Directed bench: three streamer configurations driven from a vector table,
// plus hand-written latency, held-start, abort and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_mat_uart_streamer;

  localparam int NI     = 3;
  localparam int TX_LEN = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_v  [NI];
  logic        colm_v   [NI];
  logic        abort_v  [NI];
  logic        rd_en    [NI];
  logic [5:0]  rd_addr  [NI];
  logic [15:0] rd_data  [NI];
  logic        tx_start [NI];
  logic [7:0]  tx_byte  [NI];
  logic        tx_busy  [NI];
  logic        busy_v   [NI];
  logic        done_v   [NI];
  logic        abrt_v   [NI];
  logic [2:0]  ec_a, ec_b;
  logic [1:0]  ec_c;

  mat_uart_streamer #(.ROWS(2), .COLS(2), .DATA_W(8), .ADDR_W(6)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .col_major(colm_v[0]), .abort(abort_v[0]),
    .mem_rd_en(rd_en[0]), .mem_rd_addr(rd_addr[0]), .mem_rd_data(rd_data[0][7:0]),
    .tx_start(tx_start[0]), .tx_byte(tx_byte[0]), .tx_busy(tx_busy[0]),
    .busy(busy_v[0]), .done(done_v[0]), .aborted(abrt_v[0]), .elem_cnt(ec_a));

  mat_uart_streamer #(.ROWS(2), .COLS(3), .DATA_W(8), .ADDR_W(6)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .col_major(colm_v[1]), .abort(abort_v[1]),
    .mem_rd_en(rd_en[1]), .mem_rd_addr(rd_addr[1]), .mem_rd_data(rd_data[1][7:0]),
    .tx_start(tx_start[1]), .tx_byte(tx_byte[1]), .tx_busy(tx_busy[1]),
    .busy(busy_v[1]), .done(done_v[1]), .aborted(abrt_v[1]), .elem_cnt(ec_b));

  mat_uart_streamer #(.ROWS(1), .COLS(2), .DATA_W(16), .ADDR_W(6)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .col_major(colm_v[2]), .abort(abort_v[2]),
    .mem_rd_en(rd_en[2]), .mem_rd_addr(rd_addr[2]), .mem_rd_data(rd_data[2]),
    .tx_start(tx_start[2]), .tx_byte(tx_byte[2]), .tx_busy(tx_busy[2]),
    .busy(busy_v[2]), .done(done_v[2]), .aborted(abrt_v[2]), .elem_cnt(ec_c));

  // Memory, transmitter and monitor state, all updated on the falling edge
  logic [15:0] mem      [NI][8];
  logic        pend_v   [NI];
  logic [5:0]  pend_a   [NI];
  int          tx_cnt   [NI];
  logic [7:0]  rx_q     [NI][$];
  int          done_cnt [NI];
  int          abrt_cnt [NI];
  int          done_busy[NI];
  int          unstable [NI];
  int          done_run [NI];
  int          done_wmax[NI];
  logic        prev_st  [NI];
  logic [7:0]  prev_byte[NI];

  int tests = 0;
  int fails = 0;

  initial begin
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 8; k++) mem[i][k] = 16'h0000;
      rd_data[i] = 16'hDEAD;
      pend_v[i] = 1'b0; pend_a[i] = '0;
      tx_busy[i] = 1'b0; tx_cnt[i] = 0;
      done_cnt[i] = 0; abrt_cnt[i] = 0; done_busy[i] = 0; unstable[i] = 0;
      done_run[i] = 0; done_wmax[i] = 0; prev_st[i] = 1'b0; prev_byte[i] = 8'h00;
    end
    mem[0][0] = 16'h0011; mem[0][1] = 16'h0022; mem[0][2] = 16'h0033; mem[0][3] = 16'h0044;
    for (int k = 0; k < 6; k++) mem[1][k] = 16'(k);
    mem[2][0] = 16'hA1B2; mem[2][1] = 16'hC3D4;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        rd_data[i] = pend_v[i] ? mem[i][pend_a[i][2:0]] : 16'hDEAD;
        pend_v[i]  = rd_en[i];
        pend_a[i]  = rd_addr[i];
        if (!rst_n) begin
          tx_busy[i] = 1'b0; tx_cnt[i] = 0;
        end else if (tx_busy[i]) begin
          if (tx_cnt[i] == 0) tx_busy[i] = 1'b0;
          else tx_cnt[i] = tx_cnt[i] - 1;
        end else if (tx_start[i]) begin
          rx_q[i].push_back(tx_byte[i]);
          tx_busy[i] = 1'b1;
          tx_cnt[i]  = TX_LEN;
        end
        if (done_v[i]) begin
          done_cnt[i]++; done_run[i]++;
          if (busy_v[i]) done_busy[i]++;
        end else begin
          done_run[i] = 0;
        end
        if (done_run[i] > done_wmax[i]) done_wmax[i] = done_run[i];
        if (abrt_v[i]) abrt_cnt[i]++;
        if (tx_start[i] && prev_st[i] && (tx_byte[i] !== prev_byte[i])) unstable[i]++;
        prev_st[i]   = tx_start[i];
        prev_byte[i] = tx_byte[i];
      end
    end
  end

  typedef struct {
    int          inst;
    bit          colm;
    int          nb;
    logic [63:0] exp;   // expected bytes, first byte in [63:56]
    int          ne;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int elem_of(input int i);
    case (i)
      0:       return int'(ec_a);
      1:       return int'(ec_b);
      default: return int'(ec_c);
    endcase
  endfunction

  function automatic int rx_at(input int i, input int k);
    if (k < rx_q[i].size()) return int'(rx_q[i][k]);
    return -1;
  endfunction

  task automatic clear(input int i);
    rx_q[i].delete();
    done_cnt[i] = 0; abrt_cnt[i] = 0; done_busy[i] = 0;
    unstable[i] = 0; done_wmax[i] = 0;
  endtask

  task automatic pulse_start(input int i, input bit colm);
    @(negedge clk);
    colm_v[i]  = colm;
    start_v[i] = 1'b1;
    repeat (2) @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string name);
    int n;
    n = 0;
    while (done_cnt[i] == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, " done seen"}, int'(done_cnt[i] > 0), 1);
  endtask

  task automatic check_bytes(input int i, input string name, input int nb, input logic [63:0] e);
    check({name, " nbytes"}, rx_q[i].size(), nb);
    for (int k = 0; k < nb; k++)
      check($sformatf("%s byte%0d", name, k), rx_at(i, k), int'(e[63-8*k -: 8]));
  endtask

  task automatic run_vec(input int v);
    int    i;
    string nm;
    i  = vecs[v].inst;
    nm = $sformatf("vec%0d", v);
    clear(i);
    pulse_start(i, vecs[v].colm);
    wait_done(i, nm);
    repeat (5) @(negedge clk);
    check_bytes(i, nm, vecs[v].nb, vecs[v].exp);
    check({nm, " done count"}, done_cnt[i], 1);
    check({nm, " done width"}, done_wmax[i], 1);
    check({nm, " done with busy"}, done_busy[i], 0);
    check({nm, " tx_byte unstable"}, unstable[i], 0);
    check({nm, " elem_cnt"}, elem_of(i), vecs[v].ne);
    check({nm, " busy after"}, int'(busy_v[i]), 0);
    check({nm, " aborted count"}, abrt_cnt[i], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, busy_lat, rd_lat, tx_lat, rd_cycles;
    bit found;

    vecs[0] = '{inst: 0, colm: 1'b0, nb: 4, exp: 64'h11223344_00000000, ne: 4};
    vecs[1] = '{inst: 1, colm: 1'b1, nb: 6, exp: 64'h00030104_02050000, ne: 6};
    vecs[2] = '{inst: 2, colm: 1'b0, nb: 4, exp: 64'hA1B2C3D4_00000000, ne: 2};
    vecs[3] = '{inst: 1, colm: 1'b0, nb: 6, exp: 64'h00010203_04050000, ne: 6};
    vecs[4] = '{inst: 0, colm: 1'b1, nb: 4, exp: 64'h11332244_00000000, ne: 4};
    vecs[5] = '{inst: 2, colm: 1'b1, nb: 4, exp: 64'hA1B2C3D4_00000000, ne: 2};

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; colm_v[i] = 1'b0; abort_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("reset outputs", {tx_start[0], busy_v[0], rd_en[0], done_v[0], abrt_v[0]}, 0);
    check("reset tx_byte/addr/elem", {tx_byte[0], 2'b00, rd_addr[0], 5'b0, ec_a}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < NV; v++) run_vec(v);

    // Start-to-request latency
    clear(0);
    busy_lat = -1; rd_lat = -1; tx_lat = -1; rd_cycles = 0;
    @(negedge clk);
    colm_v[0] = 1'b0; start_v[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 2) start_v[0] = 1'b0;
      if (busy_lat < 0 && busy_v[0]) busy_lat = c;
      if (rd_lat < 0 && rd_en[0]) rd_lat = c;
      if (tx_lat < 0 && rd_en[0]) rd_cycles++;
      if (tx_lat < 0 && tx_start[0]) tx_lat = c;
    end
    check("latency busy vs rd_en", rd_lat, busy_lat);
    check("latency busy to tx_start", tx_lat - busy_lat, 2);
    check("latency rd_en cycles", rd_cycles, 1);
    wait_done(0, "latency");
    repeat (5) @(negedge clk);

    // Held start gives one frame; a fresh edge gives another
    clear(0);
    @(negedge clk);
    colm_v[0] = 1'b0; start_v[0] = 1'b1;
    wait_done(0, "hold");
    repeat (100) @(negedge clk);
    check("hold done count", done_cnt[0], 1);
    check("hold nbytes", rx_q[0].size(), 4);
    check("hold busy", int'(busy_v[0]), 0);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    clear(0);
    pulse_start(0, 1'b0);
    wait_done(0, "hold2");
    repeat (5) @(negedge clk);
    check_bytes(0, "hold2", 4, 64'h11223344_00000000);

    // Abort while idle is ignored
    clear(0);
    @(negedge clk);
    abort_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    abort_v[0] = 1'b0;
    check("idle abort pulses", abrt_cnt[0], 0);
    check("idle abort elem_cnt", elem_of(0), 4);

    // Abort during the second byte's wait
    clear(0);
    pulse_start(0, 1'b0);
    n = 0; found = 0;
    while (!found && n < 2000) begin
      @(negedge clk);
      n++;
      found = (rx_q[0].size() == 2) && !tx_start[0] && tx_busy[0];
    end
    check("abort reached wait", int'(found), 1);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    check("abort tx_start", int'(tx_start[0]), 0);
    check("abort pulse", int'(abrt_v[0]), 1);
    check("abort busy", int'(busy_v[0]), 0);
    @(negedge clk);
    check("abort pulse width", int'(abrt_v[0]), 0);
    repeat (60) @(negedge clk);
    check("abort done count", done_cnt[0], 0);
    check("abort count", abrt_cnt[0], 1);
    check("abort elem_cnt", elem_of(0), 1);
    check("abort nbytes", rx_q[0].size(), 2);

    // Reset during the third byte
    clear(0);
    pulse_start(0, 1'b0);
    n = 0;
    while (rx_q[0].size() < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reset reached byte3", rx_q[0].size(), 3);
    rst_n = 1'b0;
    #1;
    check("midreset flags", {tx_start[0], busy_v[0], rd_en[0], done_v[0], abrt_v[0]}, 0);
    check("midreset tx_byte", tx_byte[0], 0);
    check("midreset addr", rd_addr[0], 0);
    check("midreset elem_cnt", elem_of(0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset done count", done_cnt[0], 0);
    check("midreset aborted count", abrt_cnt[0], 0);
    clear(0);
    pulse_start(0, 1'b0);
    wait_done(0, "post reset");
    repeat (5) @(negedge clk);
    check_bytes(0, "post reset", 4, 64'h11223344_00000000);
    check("post reset elem_cnt", elem_of(0), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mat_uart_streamer.md
# mat_uart_streamer

Parametrised streamer that reads a ROWS×COLS matrix from the result memory and feeds it, byte by byte, to the UART transmitter. It replaces the fixed 2×2 memory-to-TX path with several additions: configurable dimensions and element width, row- or column-major order, a proper transmitter handshake, abort, and busy/done status. It sits between the matrix memory read port and `transmitter`, in the `clk` domain.

## Interface
- `ROWS`, default 2: matrix rows, at least 1.
- `COLS`, default 2: matrix columns, at least 1.
- `DATA_W`, default 8: element width; must be a multiple of 8.
- `ADDR_W`, default 6: memory address width; requires ROWS*COLS ≤ 2^ADDR_W.
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: level input, rising-edge detected internally; requests one frame.
- `col_major` in 1: traversal order, sampled on the accepted start edge.
- `abort` in 1: synchronous, level; terminates the frame.
- `mem_rd_en` out 1: read strobe to the memory.
- `mem_rd_addr` out ADDR_W: read address.
- `mem_rd_data` in DATA_W: read data, valid exactly 1 cycle after `mem_rd_en`.
- `tx_start` out 1: byte request to the transmitter.
- `tx_byte` out 8: byte to send.
- `tx_busy` in 1: transmitter status from the bclk domain; double-flop synchronised inside.
- `busy` out 1: high while a frame is active.
- `done` out 1: 1-cycle pulse when the last byte has completed.
- `aborted` out 1: 1-cycle pulse when the frame ends via abort.
- `elem_cnt` out $clog2(ROWS*COLS+1): number of elements fully sent in the current or last frame.

## Operation
- Byte order:
  - BYTES = DATA_W/8.
  - Each element is sent MSB byte first.
  - Frame length is ROWS*COLS*BYTES bytes.
- Traversal:
  - Element (r,c) is at address r*COLS+c.
  - Row-major order: the address increments by 1.
  - Column-major order: the address increments by COLS; at the end of a column it restarts at c+1.
  - Both orders use add-only counters; no multiplier.
- State machine:
  - IDLE: on a start rising edge, go to READ. Clear `elem_cnt`, address = 0, latch `col_major`.
  - READ: `mem_rd_en`=1 for 1 cycle, then go to LOAD.
  - LOAD: capture `mem_rd_data` into the shift register, set byte index = 0, go to SEND.
  - SEND: `tx_start`=1 with `tx_byte` = current byte. Hold until the synchronised `tx_busy` is seen high, then go to WAIT_TX.
  - WAIT_TX: wait for synchronised `tx_busy` to go low.
    - If more bytes remain in the element: shift, go to SEND.
    - Else if more elements remain: increment `elem_cnt`, advance the address, go to READ.
    - Else: increment `elem_cnt`, pulse `done`, go to IDLE.
- Start edges are ignored while `busy`=1. Holding `start` high produces exactly one frame.
- Abort:
  - In any non-IDLE state, `abort`=1 sends the block to IDLE on the next edge.
  - `tx_start` drops immediately; a byte already accepted by the transmitter completes on its own.
  - Pulses `aborted`, not `done`. `elem_cnt` keeps its value.
  - Abort in IDLE has no effect.
- Abort has priority over `tx_busy` events in the same cycle.

## Timing
- Reset values: every output is 0; state is IDLE; the synchronisers are cleared. Reset mid-frame discards the frame with no `done` or `aborted` pulse.
- Latency: start edge in cycle 0 gives `busy` and state READ in cycle 1, and the first `tx_start` in cycle 3.
- Handshake: `tx_start` stays high until the synchronised busy is high (2–3 clk after the transmitter raises it), so no request is lost across clock rates. `tx_byte` is stable whenever `tx_start`=1.
- `done` is asserted the cycle after busy-low is observed for the final byte. `busy` falls in the same cycle `done` is asserted.
- Each new element costs 3 clk (READ, LOAD, SEND) beyond the UART byte time.
- Boundary conditions:
  - ROWS=COLS=1 gives a single-element frame.
  - The last address is ROWS*COLS-1; the address does not wrap within a frame.

## Structure
- Shared package `mat_pkg` holds the state encoding (IDLE, READ, LOAD, SEND, WAIT_TX) and the `BYTES` derivation.
- Sub-module `sync_edge`: 2-flop synchroniser plus rising-edge detector. Used for `tx_busy` (level output) and `start` (pulse output); it supersedes `level_det`.

## Test plan
- 2×2, DATA_W=8, row-major, memory {0x11,0x22,0x33,0x44}, start pulse → bytes 0x11,0x22,0x33,0x44; `done` high for 1 cycle; `elem_cnt`=4.
- 2×3, column-major, memory 0..5 → bytes 0,3,1,4,2,5.
- DATA_W=16, 1×2, memory {0xA1B2,0xC3D4} → bytes 0xA1,0xB2,0xC3,0xD4.
- `start` held high for the whole frame plus 100 cycles → exactly one frame; a second rising edge after `done` → a second identical frame.
- 2×2, `abort` asserted while the 2nd byte is in WAIT_TX → `tx_start`=0 next cycle; `aborted` pulses; `elem_cnt`=1; no `done`.
- `rst_n` low during the 3rd byte → all outputs 0 asynchronously; after release, a new start gives a full frame from address 0.
